din_packer: RTL

Upstream feeder for the 3-way select mux. Accepts 3-bit fields one per handshake and assembles them, in arrival order, into the 12-bit packed word {sel, in1, in2, in3}. The mux consumes that word as its din. The word is held in an output register behind a valid/ready handshake, so the mux input is stable and glitch-free. Collection of the next word overlaps with the held word.

---
 rtl/din_packer_if.sv | 23 ++
 rtl/din_packer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/din_packer_if.sv
// din_packer_if: field-input and packed-word-output handshakes of din_packer.
// The slave modport is the packer itself; the master modport is its environment,
// which supplies fields and consumes packed words.
interface din_packer_if #(
  parameter int FIELD_W = 3
);
  logic                 in_valid;
  logic                 in_ready;
  logic [FIELD_W-1:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [4*FIELD_W-1:0] out_word;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_word
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_word
  );
endinterface

// File: rtl/din_packer.sv
// din_packer: collects four FIELD_W-bit fields (sel, in1, in2, in3), one per
// accepted handshake, into the word {sel, in1, in2, in3} for the select mux.
// The word sits in a registered output stage behind valid/ready while the
// next word is being collected; only the completing field can stall.
// Optional build macro DIN_PACKER_STATS_EN adds word_count and stall_count.
module din_packer #(
  parameter int FIELD_W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  din_packer_if.slave  bus
`ifdef DIN_PACKER_STATS_EN
  ,
  output logic [15:0]  word_count,
  output logic [15:0]  stall_count
`else
  // statistics ports are absent in this build
`endif
);

  localparam int WORD_W = 4 * FIELD_W;

  // Field position within the word being collected.
  typedef enum logic [1:0] {
    CNT0 = 2'd0,
    CNT1 = 2'd1,
    CNT2 = 2'd2,
    CNT3 = 2'd3
  } cnt_t;

  cnt_t              cnt_reg;
  cnt_t              cnt_next;
  logic [WORD_W-1:0] out_word_reg;
  logic              out_valid_reg;
  logic              in_ready;
  logic              accept;
  logic              complete;
  logic              consume;

  // Only the completing field has to wait for the output register to free up;
  // a consume on the same edge frees it, so there is no bubble.
  assign consume  = out_valid_reg && bus.out_ready;
  assign in_ready = rst_n && !flush &&
                    !((cnt_reg == CNT3) && out_valid_reg && !bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign complete = accept && (cnt_reg == CNT3);

  // Field counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= CNT0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // Next field position: advance on accept, restart on flush or completion.
  always_comb begin
    cnt_next = cnt_reg;
    if (flush) begin
      cnt_next = CNT0;
    end else if (accept) begin
      unique case (cnt_reg)
        CNT0:    cnt_next = CNT1;
        CNT1:    cnt_next = CNT2;
        CNT2:    cnt_next = CNT3;
        default: cnt_next = CNT0;
      endcase
    end
  end

  // Staging slots for sel, in1, in2; the last field goes straight to out_word.
  for (genvar gi = 0; gi < 3; gi++) begin : g_stg
    logic [FIELD_W-1:0] slot_reg;

    // Capture the field whose position matches this slot.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_reg <= '0;
      end else if (accept && (cnt_reg == cnt_t'(2'(gi)))) begin
        slot_reg <= bus.in_data;
      end
    end
  end

  // Output register: load on the completing field, drop valid on a consume
  // unless a new word replaces the old one on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_word_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else if (complete) begin
      out_word_reg  <= {g_stg[0].slot_reg, g_stg[1].slot_reg,
                        g_stg[2].slot_reg, bus.in_data};
      out_valid_reg <= 1'b1;
    end else if (consume) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_word  = out_word_reg;

`ifdef DIN_PACKER_STATS_EN
  logic [15:0] word_count_reg;
  logic [15:0] stall_count_reg;

  // Free-running wrap-around counters of consumed words and refused field offers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count_reg  <= '0;
      stall_count_reg <= '0;
    end else begin
      if (consume) begin
        word_count_reg <= word_count_reg + 16'd1;
      end
      if (bus.in_valid && !in_ready) begin
        stall_count_reg <= stall_count_reg + 16'd1;
      end
    end
  end

  assign word_count  = word_count_reg;
  assign stall_count = stall_count_reg;
`else
  // no statistics counters in this build
`endif

endmodule
